swap_sequencer: RTL and testbench
=================================

Name: swap_sequencer

Overview:
- Command front-end sitting directly upstream of the 4-register crossbar swap datapath.
- Accepts buffered LOAD/SWAP commands over a valid/ready handshake and drives the datapath's Data, RinExt, Extern and w inputs with correct timing.
- Holds off the next command until the datapath's 2-bit shift-register controller has finished its swap sequence.

Parameters:
- DEPTH, 2, command FIFO entries (power of 2, ≥2).
- SWAP_GAP, 3, idle cycles after the w pulse before the next command may issue; covers the m=2 shift controller plus one margin cycle.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- CmdValid  in  1  command present.
- CmdReady  out  1  FIFO can accept; equals !full.
- CmdOp  in  2  01=LOAD, 10=SWAP, 00/11=invalid.
- CmdReg  in  2  target register for LOAD; 0..3 maps to R1..R4.
- CmdData  in  8  LOAD value.
- Data  out  8  datapath data bus.
- RinExt  out  [1:4]  one-hot external register enables.
- Extern  out  1  external-load qualifier.
- w  out  1  swap-start pulse to the shift controller.
- Busy  out  1  state != IDLE or FIFO non-empty.
- Done  out  1  one-cycle pulse on the last cycle of each executed command.

Behaviour:
- Reset (async, any time, including mid-operation):
  - FIFO flushed; state=IDLE.
  - Data=0, RinExt=0000, Extern=0, w=0, Done=0, Busy=0, CmdReady=1.
  - Takes effect immediately; the first accept is possible at the first rising edge after deassertion.
- Handshake:
  - Push on rising edge when CmdValid&CmdReady.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Full blocks push; no overwrite.
  - Pointers wrap modulo DEPTH.
  - The FIFO is first-word-fall-through internally.
- FSM states: IDLE, LOAD, SWAP_W, SWAP_WAIT. All outputs are registered.
- IDLE:
  - If FIFO non-empty: pop the head.
  - LOAD → LOAD state. SWAP → SWAP_W. Invalid → dropped, stay IDLE, no Done.
  - If empty, stay in IDLE.
- LOAD (1 cycle):
  - Data=CmdData, RinExt=one-hot(CmdReg), Extern=1, Done=1.
  - Next state: IDLE.
- SWAP_W (1 cycle):
  - w=1, RinExt=0000, Extern=0.
  - Data holds its last value.
  - Next state: SWAP_WAIT with gap counter=SWAP_GAP-1.
- SWAP_WAIT:
  - w=0; counter decrements each cycle.
  - On counter==0: Done=1, then go to IDLE.
- Latency:
  - A command pushed at edge N into an empty idle block drives its outputs in cycle N+2 (pop at edge N+1, registered outputs at edge N+2).
  - LOAD throughput: one command per 2 cycles (IDLE+LOAD).
  - SWAP occupancy: 1+SWAP_GAP cycles plus the IDLE cycle.
- Output rules:
  - RinExt, Extern and w are never asserted together.
  - RinExt has exactly one bit high in LOAD and is zero otherwise.
- Gap counter width: clog2(SWAP_GAP)+1. SWAP_GAP=1 yields a single SWAP_WAIT cycle.

Optional Feature:
- Macro: SWAP_SEQ_STATUS_EN.
- Defined:
  - Adds output CmdCount[15:0], counting executed (Done) commands; wraps 0xFFFF→0; reset to 0.
  - Adds output DropErr, sticky 1 once an invalid opcode is dropped; cleared only by Reset.
- Undefined: neither port exists; core behaviour is identical.

Test Plan:
- Reset behaviour: assert Reset mid-SWAP_WAIT with 2 entries queued → all outputs 0 immediately; after release, CmdReady=1 and Busy=0; queued commands are never executed.
- Single LOAD: LOAD reg=2 data=0xA5 accepted at edge N → at cycle N+2, Data=0xA5, RinExt=0010, Extern=1, Done=1; all strobes low in N+3.
- SWAP timing: SWAP accepted, SWAP_GAP=3 → w high for exactly 1 cycle, then 3 cycles with w=0, Done on the 3rd; the next queued LOAD issues no earlier than the cycle after IDLE.
- Backpressure: DEPTH=2, hold CmdValid while issuing SWAP, LOAD r0 0x11, LOAD r3 0x22 → CmdReady drops when 2 entries are pending; all three execute in order with RinExt 1000 then 0001, Data 0x11 then 0x22.
- Invalid opcode: CmdOp=11 between two LOADs → dropped; exactly 2 Done pulses; DropErr=1 and CmdCount=2 when SWAP_SEQ_STATUS_EN is defined.
- Wrap: push/pop 5 LOADs back-to-back with DEPTH=2 → pointers wrap; output order and values match input order; Busy falls one cycle after the final Done.

Source files
------------

// File: rtl/swap_sequencer.sv
// Command front-end for the 4-register crossbar swap datapath: buffers LOAD/SWAP commands and sequences Data/RinExt/Extern/w.
// Optional status outputs (o_cmd_count, o_drop_err) are built when SWAP_SEQ_STATUS_EN is defined.
module swap_sequencer #(
  parameter int DEPTH    = 2,
  parameter int SWAP_GAP = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [1:0] i_cmd_reg,
  input  logic [7:0] i_cmd_data,
  output logic [7:0] o_data,
  output logic [1:4] o_rin_ext,
  output logic       o_extern,
  output logic       o_w,
  output logic       o_busy,
  output logic       o_done
`ifdef SWAP_SEQ_STATUS_EN
  ,
  output logic [15:0] o_cmd_count,
  output logic        o_drop_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SWAP_GAP) + 1;

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_SWAP_W    = 2'd2;
  localparam logic [1:0] ST_SWAP_WAIT = 2'd3;

  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] GAP_INIT = CW'(SWAP_GAP - 1);

  logic [11:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [1:0]    r_state;
  logic [CW-1:0] r_gap_cnt;
  logic [1:0]    r_cmd_reg;
  logic [7:0]    r_cmd_data;

  logic [7:0]    r_data;
  logic [1:4]    r_rin_ext;
  logic          r_extern;
  logic          r_w;
  logic          r_busy;
  logic          r_done;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [11:0]   w_head;
  logic [1:0]    w_head_op;
  logic [1:0]    w_head_reg;
  logic [7:0]    w_head_data;
  logic [1:0]    w_state_next;
  logic [CW-1:0] w_gap_next;
  logic          w_load_cmd;
  logic          w_done_next;
  logic [1:4]    w_onehot;

  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = i_cmd_valid && !w_full;
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_op   = w_head[11:10];
  assign w_head_reg  = w_head[9:8];
  assign w_head_data = w_head[7:0];

  // Storage is not reset; the async reset flushes by clearing the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_cmd_op, i_cmd_reg, i_cmd_data};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap_cnt;
    w_load_cmd   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          case (w_head_op)
            OP_LOAD: begin
              w_state_next = ST_LOAD;
              w_load_cmd   = 1'b1;
            end
            OP_SWAP: w_state_next = ST_SWAP_W;
            default: w_state_next = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: w_state_next = ST_IDLE;
      ST_SWAP_W: begin
        w_state_next = ST_SWAP_WAIT;
        w_gap_next   = GAP_INIT;
      end
      ST_SWAP_WAIT: begin
        if (r_gap_cnt == '0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_gap_next = r_gap_cnt - CW'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_gap_cnt  <= '0;
      r_cmd_reg  <= '0;
      r_cmd_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_gap_cnt <= w_gap_next;
      if (w_load_cmd) begin
        r_cmd_reg  <= w_head_reg;
        r_cmd_data <= w_head_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_onehot
      assign w_onehot[gi+1] = (r_cmd_reg == 2'(gi));
    end
  endgenerate

  assign w_done_next = (r_state == ST_LOAD) ||
                       ((r_state == ST_SWAP_WAIT) && (r_gap_cnt == '0));

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data    <= '0;
      r_rin_ext <= '0;
      r_extern  <= 1'b0;
      r_w       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (r_state == ST_LOAD) begin
        r_data <= r_cmd_data;
      end
      r_rin_ext <= (r_state == ST_LOAD) ? w_onehot : 4'b0000;
      r_extern  <= (r_state == ST_LOAD);
      r_w       <= (r_state == ST_SWAP_W);
      r_busy    <= (r_state != ST_IDLE) || !w_empty;
      r_done    <= w_done_next;
    end
  end

  assign o_cmd_ready = !w_full;
  assign o_data      = r_data;
  assign o_rin_ext   = r_rin_ext;
  assign o_extern    = r_extern;
  assign o_w         = r_w;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

`ifdef SWAP_SEQ_STATUS_EN
  logic [15:0] r_cmd_count;
  logic        r_drop_err;
  logic        w_drop;

  assign w_drop = w_pop && (w_head_op != OP_LOAD) && (w_head_op != OP_SWAP);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd_count <= '0;
      r_drop_err  <= 1'b0;
    end else begin
      if (w_done_next) begin
        r_cmd_count <= r_cmd_count + 16'd1;
      end
      if (w_drop) begin
        r_drop_err <= 1'b1;
      end
    end
  end

  assign o_cmd_count = r_cmd_count;
  assign o_drop_err  = r_drop_err;
`endif

endmodule

// File: tb/tb_swap_sequencer.sv
// Scoreboard bench for swap_sequencer: expected strobes queued at accept, matched by a negedge monitor.
module tb_swap_sequencer;
  localparam int DEPTH    = 2;
  localparam int SWAP_GAP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [1:0] op = '0;
  logic [1:0] rg = '0;
  logic [7:0] din = '0;
  logic       o_cmd_ready;
  logic [7:0] o_data;
  logic [1:4] o_rin_ext;
  logic       o_extern;
  logic       o_w;
  logic       o_busy;
  logic       o_done;
`ifdef SWAP_SEQ_STATUS_EN
  logic [15:0] o_cmd_count;
  logic        o_drop_err;
`endif

  swap_sequencer #(.DEPTH(DEPTH), .SWAP_GAP(SWAP_GAP)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(op), .i_cmd_reg(rg), .i_cmd_data(din), .o_data(o_data),
    .o_rin_ext(o_rin_ext), .o_extern(o_extern), .o_w(o_w), .o_busy(o_busy),
    .o_done(o_done)
`ifdef SWAP_SEQ_STATUS_EN
    , .o_cmd_count(o_cmd_count), .o_drop_err(o_drop_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_swap;
    logic [7:0] data;
    logic [3:0] rin;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_done_cyc = -100;
  int         swap_w_cyc = 0;
  int         done_total = 0;
  int         sent_valid = 0;
  bit         pending_swap = 1'b0;
  logic [7:0] last_load_data = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe the DUT raises must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_done) done_total++;
      if (o_w) chk("w_exclusive", 32'({o_extern, o_rin_ext}), 32'd0);
      if (o_extern || (o_rin_ext != 4'b0000))
        chk("rin_onehot_ext", 32'(o_extern && ($countones(o_rin_ext) == 1)), 32'd1);
      if (o_extern) begin
        if (sb.size() == 0) chk("unexpected_load", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          $display("txn LOAD cyc=%0d data=0x%0h rin=%b", cyc, o_data, o_rin_ext);
          chk("load_kind", 32'(e.is_swap), 32'd0);
          chk("load_data", 32'(o_data), 32'(e.data));
          chk("load_rin", 32'(o_rin_ext), 32'(e.rin));
          chk("load_done", 32'(o_done), 32'd1);
          chk("done_spacing", 32'((cyc - last_done_cyc) >= 2), 32'd1);
          last_done_cyc  = cyc;
          last_load_data = e.data;
        end
      end else if (o_w) begin
        chk("w_single", 32'(pending_swap), 32'd0);
        if (sb.size() == 0) chk("unexpected_w", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          $display("txn SWAP_W cyc=%0d", cyc);
          chk("w_kind", 32'(e.is_swap), 32'd1);
        end
        chk("w_done_low", 32'(o_done), 32'd0);
        chk("swap_data_hold", 32'(o_data), 32'(last_load_data));
        pending_swap = 1'b1;
        swap_w_cyc   = cyc;
      end else if (o_done) begin
        $display("txn SWAP_DONE cyc=%0d", cyc);
        chk("done_expected", 32'(pending_swap), 32'd1);
        chk("swap_gap", 32'(cyc - swap_w_cyc), 32'(SWAP_GAP));
        chk("swap_data_hold_done", 32'(o_data), 32'(last_load_data));
        pending_swap  = 1'b0;
        last_done_cyc = cyc;
      end else if (pending_swap && ((cyc - swap_w_cyc) > SWAP_GAP)) begin
        chk("swap_done_timeout", 32'd0, 32'd1);
        pending_swap = 1'b0;
      end
    end
  end

  task automatic send(input logic [1:0] c_op, input logic [1:0] c_reg, input logic [7:0] c_data);
    int t = 0;
    @(negedge clk);
    valid = 1'b1; op = c_op; rg = c_reg; din = c_data;
    while (!o_cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'd1, 32'd0);
    if (c_op == 2'b01) begin
      sb.push_back('{is_swap: 1'b0, data: c_data, rin: 4'b1000 >> c_reg});
      sent_valid++;
    end else if (c_op == 2'b10) begin
      sb.push_back('{is_swap: 1'b1, data: 8'h00, rin: 4'b0000});
      sent_valid++;
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk); #1;
    while ((o_busy || sb.size() != 0 || pending_swap) && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("drain_timeout", 32'(t >= 2000), 32'd0);
  endtask

  initial begin
    int t;
    int done_before;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_rin", 32'(o_rin_ext), 32'd0);
    chk("rst_strobes", 32'({o_extern, o_w, o_done, o_busy}), 32'd0);
    chk("rst_ready", 32'(o_cmd_ready), 32'd1);
    @(negedge clk) rst = 1'b0;

    // Single LOAD latency: outputs two edges after accept, then low.
    send(2'b01, 2'd2, 8'hA5);
    @(negedge clk); #1 chk("lat_n_done", 32'(o_done), 32'd0);
    @(negedge clk); #1 chk("lat_n1_strobe", 32'({o_done, o_extern}), 32'd0);
    @(negedge clk); #1;
    chk("lat_data", 32'(o_data), 32'hA5);
    chk("lat_rin", 32'(o_rin_ext), 32'b0010);
    chk("lat_ext_done", 32'({o_extern, o_done}), 32'b11);
    @(negedge clk); #1 chk("lat_after_low", 32'({o_extern, o_done, o_w, o_rin_ext}), 32'd0);
    wait_idle();

    // SWAP followed by a queued LOAD.
    send(2'b10, 2'd0, 8'h00);
    send(2'b01, 2'd1, 8'h3C);
    wait_idle();

    // Backpressure with the FIFO filling behind a SWAP.
    send(2'b10, 2'd0, 8'h00);
    send(2'b01, 2'd0, 8'h11);
    send(2'b01, 2'd3, 8'h22);
    chk("bp_ready_low", 32'(o_cmd_ready), 32'd0);
    wait_idle();

    // Invalid opcodes between two LOADs are dropped.
`ifdef SWAP_SEQ_STATUS_EN
    chk("drop_err_clear", 32'(o_drop_err), 32'd0);
`endif
    done_before = done_total;
    send(2'b01, 2'd1, 8'h5A);
    send(2'b11, 2'd0, 8'hFF);
    send(2'b00, 2'd3, 8'h77);
    send(2'b01, 2'd2, 8'h6B);
    wait_idle();
    chk("invalid_done_count", 32'(done_total - done_before), 32'd2);
`ifdef SWAP_SEQ_STATUS_EN
    chk("drop_err_set", 32'(o_drop_err), 32'd1);
    chk("cmd_count", 32'(o_cmd_count), 32'(sent_valid));
`endif

    // Five back-to-back LOADs wrap the pointers; Busy falls one cycle after the last Done.
    for (int i = 0; i < 5; i++) send(2'b01, 2'(i), 8'(8'h81 + i));
    t = 0;
    @(negedge clk); #1;
    while (!(o_done && sb.size() == 0) && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk("wrap_final_done_seen", 32'(t >= 200), 32'd0);
    chk("wrap_busy_at_done", 32'(o_busy), 32'd1);
    @(negedge clk); #1 chk("wrap_busy_fall", 32'(o_busy), 32'd0);
    wait_idle();

    // Reset during SWAP_WAIT with two LOADs still queued.
    send(2'b10, 2'd0, 8'h00);
    send(2'b01, 2'd1, 8'h44);
    send(2'b01, 2'd2, 8'h55);
    t = 0;
    while (!o_w && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    chk("mid_reset_w_seen", 32'(o_w), 32'd1);
    @(negedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outputs", 32'({o_data, o_rin_ext, o_extern, o_w, o_done, o_busy}), 32'd0);
    chk("mid_rst_ready", 32'(o_cmd_ready), 32'd1);
    sb.delete();
    pending_swap   = 1'b0;
    last_load_data = '0;
    sent_valid     = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(o_cmd_ready), 32'd1);
    chk("post_rst_busy", 32'(o_busy), 32'd0);
`ifdef SWAP_SEQ_STATUS_EN
    chk("post_rst_count", 32'(o_cmd_count), 32'd0);
    chk("post_rst_drop", 32'(o_drop_err), 32'd0);
`endif
    repeat (20) @(negedge clk);
    #1 chk("post_rst_idle", 32'(o_busy), 32'd0);

    send(2'b01, 2'd3, 8'h99);
    wait_idle();
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end
endmodule
